// File: rtl/register_arbiter_pkg.sv
// Shared definitions for the round-robin register arbiter: FSM encoding,
// requester count and the per-requester data slice helper.
`ifndef REGISTER_ARBITER_PKG_SV
`define REGISTER_ARBITER_PKG_SV

// Selects requester idx's w-bit field out of a packed data bus.
`define RA_DATA_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package register_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        idx_to_onehot = '0;
        idx_to_onehot[idx] = 1'b1;
    endfunction

endpackage

`endif

// File: rtl/register_arbiter_if.sv
// Requester-side bus of the register arbiter: requests, data, hold and the
// completion/status signals returned by the arbiter.
interface register_arbiter_if #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
);
    import register_arbiter_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data_in;
    logic                  hold;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic [1:0]            owner;
    logic [CNT_WIDTH-1:0]  wr_count;

    modport master (
        output req, data_in, hold,
        input  ack, busy, q, owner, wr_count
    );

    modport slave (
        input  req, data_in, hold,
        output ack, busy, q, owner, wr_count
    );

endinterface

// File: rtl/register_arbiter_reg.sv
// Plain loadable register with a synchronous active-high clear.
module register_arbiter_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_arbiter.sv
// Round-robin arbiter sharing one register among four requesters; each write
// takes IDLE (grant) -> LOAD (register write) -> ACK (completion pulse).
module register_arbiter
    import register_arbiter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    register_arbiter_if.slave  bus
);

    state_t               state;
    state_t               next_state;
    logic                 grant;
    logic                 load;
    logic [1:0]           ptr;
    logic [1:0]           pick;
    logic [1:0]           winner;
    logic [WIDTH-1:0]     staged;
    logic [WIDTH-1:0]     q;
    logic [1:0]           owner;
    logic [CNT_WIDTH-1:0] wr_count;

    // First set request at or above ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] idx;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign pick = rr_pick(bus.req, ptr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.hold && (bus.req != '0)) begin
                    grant      = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD:    next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign load = (state == LOAD);

    // Grant stage: capture winner and its data so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner <= '0;
            staged <= '0;
        end else if (grant) begin
            winner <= pick;
            staged <= `RA_DATA_SLICE(bus.data_in, pick, WIDTH);
        end
    end

    // Write stage: bookkeeping that accompanies the register load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            owner    <= '0;
            wr_count <= '0;
        end else if (load) begin
            owner <= winner;
            ptr   <= winner + 2'd1;
            if (wr_count != {CNT_WIDTH{1'b1}}) begin
                wr_count <= wr_count + CNT_WIDTH'(1);
            end
        end
    end

    register_arbiter_reg #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clk   (clk),
        .reset (~reset),
        .load  (load),
        .d     (staged),
        .q     (q)
    );

    assign bus.ack      = (state == ACK) ? idx_to_onehot(winner) : '0;
    assign bus.busy     = (state != IDLE);
    assign bus.q        = q;
    assign bus.owner    = owner;
    assign bus.wr_count = wr_count;

endmodule

// File: tb/tb_register_arbiter.sv
// Directed bench for register_arbiter: reset, round robin, staging, hold,
// mid-transaction reset and counter saturation on a narrow-counter instance.
module tb_register_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    register_arbiter_if #(.WIDTH(16), .CNT_WIDTH(8)) bus ();
    register_arbiter_if #(.WIDTH(16), .CNT_WIDTH(2)) bus_s ();

    register_arbiter #(.WIDTH(16), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    register_arbiter #(.WIDTH(16), .CNT_WIDTH(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.req       = 4'hF;
        bus.hold      = 1'b0;
        bus.data_in   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus_s.req     = 4'h0;
        bus_s.hold    = 1'b0;
        bus_s.data_in = '0;
        tick();
        tick();
        n_checks++; if (bus.q !== 16'h0000) $display("FAIL reset_q got %h want 0000", bus.q); else n_pass++;
        n_checks++; if (bus.ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", bus.ack); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.wr_count !== 8'd0) $display("FAIL reset_wr_count got %0d want 0", bus.wr_count); else n_pass++;
        n_checks++; if (bus.owner !== 2'd0) $display("FAIL reset_owner got %0d want 0", bus.owner); else n_pass++;
        reset   = 1'b1;
        bus.req = 4'b0100;
        bus.data_in[2*16 +: 16] = 16'h00AA;
        tick();
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL single_load_busy got %b want 1", bus.busy); else n_pass++;
        n_checks++; if (bus.ack !== 4'b0000) $display("FAIL single_load_ack got %b want 0000", bus.ack); else n_pass++;
        tick();
        n_checks++; if (bus.q !== 16'h00AA) $display("FAIL single_q got %h want 00aa", bus.q); else n_pass++;
        n_checks++; if (bus.ack !== 4'b0100) $display("FAIL single_ack got %b want 0100", bus.ack); else n_pass++;
        n_checks++; if (bus.owner !== 2'd2) $display("FAIL single_owner got %0d want 2", bus.owner); else n_pass++;
        n_checks++; if (bus.wr_count !== 8'd1) $display("FAIL single_wr_count got %0d want 1", bus.wr_count); else n_pass++;
        bus.req = 4'b0000;
        tick();
        n_checks++; if (bus.ack !== 4'b0000) $display("FAIL single_ack_end got %b want 0000", bus.ack); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_q   [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
        logic [1:0]  exp_own [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0]  exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.data_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.req     = 4'hF;
        for (int g = 0; g < 5; g++) begin
            tick();
            n_checks++; if (bus.busy !== 1'b1) $display("FAIL rr_busy[%0d] got %b want 1", g, bus.busy); else n_pass++;
            n_checks++; if (bus.ack !== 4'b0000) $display("FAIL rr_load_ack[%0d] got %b want 0000", g, bus.ack); else n_pass++;
            tick();
            n_checks++; if (bus.q !== exp_q[g]) $display("FAIL rr_q[%0d] got %h want %h", g, bus.q, exp_q[g]); else n_pass++;
            n_checks++; if (bus.owner !== exp_own[g]) $display("FAIL rr_owner[%0d] got %0d want %0d", g, bus.owner, exp_own[g]); else n_pass++;
            n_checks++; if (bus.ack !== exp_ack[g]) $display("FAIL rr_ack[%0d] got %b want %b", g, bus.ack, exp_ack[g]); else n_pass++;
            tick();
            n_checks++; if (bus.ack !== 4'b0000) $display("FAIL rr_ack_end[%0d] got %b want 0000", g, bus.ack); else n_pass++;
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL rr_idle[%0d] got %b want 0", g, bus.busy); else n_pass++;
        end
        bus.req = 4'b0000;
        n_checks++; if (bus.wr_count !== 8'd5) $display("FAIL rr_wr_count got %0d want 5", bus.wr_count); else n_pass++;
    endtask

    task automatic test_staging();
        bus.req = 4'b0010;
        bus.data_in[1*16 +: 16] = 16'h4242;
        tick();
        bus.data_in[1*16 +: 16] = 16'hFFFF;
        tick();
        n_checks++; if (bus.q !== 16'h4242) $display("FAIL stage_q got %h want 4242", bus.q); else n_pass++;
        n_checks++; if (bus.ack !== 4'b0010) $display("FAIL stage_ack got %b want 0010", bus.ack); else n_pass++;
        bus.req = 4'b0000;
        tick();
        tick();
        n_checks++; if (bus.q !== 16'h4242) $display("FAIL stage_q_hold got %h want 4242", bus.q); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL stage_idle got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_hold();
        bus.hold = 1'b1;
        bus.req  = 4'b1000;
        bus.data_in[3*16 +: 16] = 16'hABCD;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_busy[%0d] got %b want 0", c, bus.busy); else n_pass++;
            n_checks++; if (bus.q !== 16'h4242) $display("FAIL hold_q[%0d] got %h want 4242", c, bus.q); else n_pass++;
        end
        bus.hold = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL hold_release_busy got %b want 1", bus.busy); else n_pass++;
        bus.hold = 1'b1;
        tick();
        n_checks++; if (bus.ack !== 4'b1000) $display("FAIL hold_in_load_ack got %b want 1000", bus.ack); else n_pass++;
        n_checks++; if (bus.q !== 16'hABCD) $display("FAIL hold_q_write got %h want abcd", bus.q); else n_pass++;
        n_checks++; if (bus.owner !== 2'd3) $display("FAIL hold_owner got %0d want 3", bus.owner); else n_pass++;
        bus.req  = 4'b0000;
        bus.hold = 1'b0;
        tick();
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL hold_idle got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b0001;
        bus.data_in[0 +: 16] = 16'h5A5A;
        tick();
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL mid_in_load got %b want 1", bus.busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_async_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.wr_count !== 8'd0) $display("FAIL mid_wr_count got %0d want 0", bus.wr_count); else n_pass++;
        tick();
        n_checks++; if (bus.q !== 16'h0000) $display("FAIL mid_q got %h want 0000", bus.q); else n_pass++;
        n_checks++; if (bus.ack !== 4'b0000) $display("FAIL mid_ack got %b want 0000", bus.ack); else n_pass++;
        bus.req = 4'b0000;
        reset   = 1'b1;
        tick();
        n_checks++; if (bus.ack !== 4'b0000) $display("FAIL mid_no_late_ack got %b want 0000", bus.ack); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL mid_idle got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bus_s.req = 4'b0001;
        for (int w = 0; w < 5; w++) begin
            bus_s.data_in[0 +: 16] = 16'h0100 + 16'(w);
            tick();
            tick();
            n_checks++; if (bus_s.wr_count !== exp_cnt[w]) $display("FAIL sat_count[%0d] got %0d want %0d", w, bus_s.wr_count, exp_cnt[w]); else n_pass++;
            n_checks++; if (bus_s.q !== 16'h0100 + 16'(w)) $display("FAIL sat_q[%0d] got %h want %h", w, bus_s.q, 16'h0100 + 16'(w)); else n_pass++;
            tick();
        end
        bus_s.req = 4'b0000;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_round_robin();
        test_staging();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
